tile_row_fetcher: RTL
=====================

Name: tile_row_fetcher

Overview:
- Read-side counterpart of tile pixel writes into tile data: fetches one 8-pixel row of a 2bpp planar tile from VRAM and streams the decoded 2-bit pixels out.
- Sits between the whizgraphics line renderer (the consumer of pixels) and the VRAM read port.
- Handles both tile-addressing modes (unsigned at VRAM offset 0x0000, signed around offset 0x1000) and optional horizontal flip for sprites.

Parameters:
- ADDR_W, 13, VRAM byte address width (8 KiB tile/map space).
- SIGNED_BASE, 13'h1000, VRAM offset of tile 0 in signed addressing mode.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  row fetch request.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid and req_ready are both high.
- tile_idx  in  8  tile number, sampled on accept.
- tile_row  in  3  row within tile (0..7), sampled on accept.
- signed_mode  in  1  1 selects signed tile_idx relative to SIGNED_BASE, sampled on accept.
- xflip  in  1  1 emits pixels bit0-first, sampled on accept.
- mem_rd  out  1  one-cycle read strobe.
- mem_addr  out  ADDR_W  read address; valid while mem_rd is high.
- mem_rdata  in  8  read data; valid with mem_rvalid.
- mem_rvalid  in  1  read data valid; arrives at least 1 cycle after mem_rd, with arbitrary latency.
- pix_valid  out  1  pixel available.
- pix_ready  in  1  consumer accepts pixel.
- pix_data  out  2  pixel value {hi_bit, lo_bit}.
- pix_last  out  1  high with the 8th pixel of the row.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - req_ready=1.
  - mem_rd=0, mem_addr=0.
  - pix_valid=0, pix_data=0, pix_last=0.
  - busy=0.
  - State IDLE.
- Base address:
  - Unsigned mode: base = tile_idx*16.
  - Signed mode: base = SIGNED_BASE + sign_extend(tile_idx)*16, computed at ADDR_W width.
  - lo_addr = base + tile_row*2; hi_addr = lo_addr + 1.
- State machine:
  - IDLE -> RD_LO on accept; the request fields are latched.
  - RD_LO: mem_rd=1, mem_addr=lo_addr for exactly one cycle; then -> WAIT_LO.
  - WAIT_LO: hold until mem_rvalid; capture mem_rdata into lo_reg; -> RD_HI.
  - RD_HI: mem_rd=1, mem_addr=hi_addr for one cycle; -> WAIT_HI.
  - WAIT_HI: on mem_rvalid, capture hi_reg, set pixel counter=0; -> SHIFT.
  - SHIFT:
    - pix_valid=1.
    - Pixel bit position b = 7-count, or count if xflip.
    - pix_data = {hi_reg[b], lo_reg[b]}.
    - pix_last = (count==7).
    - On pix_valid && pix_ready, count increments.
    - On the transfer with count==7 -> IDLE; pix_valid drops the next cycle.
- Latency with 1-cycle memory: accept in cycle 0, lo strobe cycle 1, rvalid cycle 2, hi strobe cycle 3, rvalid cycle 4, first pixel valid cycle 5. With pix_ready held high, 8 pixels are delivered in cycles 5..12 and req_ready returns in cycle 13.
- Backpressure: while pix_valid && !pix_ready, pix_data and pix_last stay stable and count is unchanged.
- mem_rvalid is ignored outside WAIT_LO/WAIT_HI, including stray or late responses in IDLE, RD_* or SHIFT.
- Inputs are latched at accept; changes to tile_idx, tile_row, signed_mode or xflip during a fetch have no effect.
- Reset asserted in any state: next cycle IDLE with all outputs at reset values; a partial row is discarded.
- No back-to-back overlap: the next request is accepted only after the row's last pixel transfers.

Test Plan:
- Unsigned mode, tile_idx=0x02, tile_row=3, 1-cycle memory -> mem_addr 0x0026 then 0x0027, each with a single-cycle mem_rd; first pix_valid in cycle 5.
- lo=0x55, hi=0x33, xflip=0, pix_ready=1 -> pix_data sequence 0,1,2,3,0,1,2,3; pix_last only on the 8th; req_ready high again in cycle 13.
- Same data with xflip=1 -> sequence 3,2,1,0,3,2,1,0.
- Signed mode, tile_idx=0x80 row 0 -> addresses 0x0800/0x0801; tile_idx=0x7F row 7 -> 0x17FE/0x17FF.
- Memory latency 4 cycles with a stray mem_rvalid in IDLE, plus pix_ready toggling 1,0,0,1,... -> stray response ignored; pixel held stable while stalled; exactly 8 transfers, no duplicates or drops.
- Reset pulsed in WAIT_HI, then a new request tile_idx=0x01 row 0 -> next cycle IDLE with pix_valid=0 and req_ready=1; new fetch addresses 0x0010/0x0011 with correct pixels.

Source files
------------

// File: rtl/tile_row_fetcher.sv
// tile_row_fetcher: fetches one 2bpp planar tile row from VRAM (lo plane, then hi plane) and streams 8 decoded pixels; ports: req_* row request, mem_* VRAM read port, pix_* pixel stream, busy
module tile_row_fetcher #(
  parameter int ADDR_W = 13,
  parameter logic [ADDR_W-1:0] SIGNED_BASE = 13'h1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [7:0]        tile_idx,
  input  logic [2:0]        tile_row,
  input  logic              signed_mode,
  input  logic              xflip,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_rvalid,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [1:0]        pix_data,
  output logic              pix_last,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, RD_LO, WAIT_LO, RD_HI, WAIT_HI, SHIFT} state_t;
  state_t state, state_n;
  logic [7:0] idx_q, lo_reg, hi_reg;
  logic [2:0] row_q, cnt, b;
  logic sm_q, xf_q, accept, xfer;
  logic [ADDR_W-1:0] off, base, lo_addr, hi_addr;
  assign accept = req_valid & req_ready;
  assign xfer = pix_valid & pix_ready;
  assign off = {{(ADDR_W-12){idx_q[7] & sm_q}}, idx_q, 4'b0000};
  assign base = sm_q ? SIGNED_BASE + off : off;
  assign lo_addr = base + ADDR_W'({row_q, 1'b0});
  assign hi_addr = lo_addr + ADDR_W'(1);
  // ~cnt is 7-cnt for a 3-bit counter: msb-first unless flipped
  assign b = xf_q ? cnt : ~cnt;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? RD_LO : IDLE;
      RD_LO:   state_n = WAIT_LO;
      WAIT_LO: state_n = mem_rvalid ? RD_HI : WAIT_LO;
      RD_HI:   state_n = WAIT_HI;
      WAIT_HI: state_n = mem_rvalid ? SHIFT : WAIT_HI;
      SHIFT:   state_n = (xfer && cnt == 3'd7) ? IDLE : SHIFT;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    req_ready = state == IDLE;
    busy = state != IDLE;
    mem_rd = state == RD_LO || state == RD_HI;
    mem_addr = state == RD_LO ? lo_addr : state == RD_HI ? hi_addr : '0;
    pix_valid = state == SHIFT;
    pix_data = state == SHIFT ? {hi_reg[b], lo_reg[b]} : 2'b00;
    pix_last = state == SHIFT && cnt == 3'd7;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
      row_q <= '0;
      sm_q <= 1'b0;
      xf_q <= 1'b0;
      lo_reg <= '0;
      hi_reg <= '0;
      cnt <= '0;
    end else begin
      if (accept) begin
        idx_q <= tile_idx;
        row_q <= tile_row;
        sm_q <= signed_mode;
        xf_q <= xflip;
      end
      if (state == WAIT_LO && mem_rvalid) lo_reg <= mem_rdata;
      if (state == WAIT_HI && mem_rvalid) begin
        hi_reg <= mem_rdata;
        cnt <= '0;
      end else if (xfer) cnt <= cnt + 3'd1;
    end
  end
endmodule
